// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32 datapath.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath mux selects,
// write enables and the 3-bit alu_control code consumed by the ALU.
// Optional feature: define CTRL_PERF_EN to add the instret retired-instruction counter port.
module multicycle_controller #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       illegal
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] instret
`endif
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal,
        StIllegal
    } state_e;

    // Opcodes recognised in DECODE
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    // ALU operation codes
    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluXor = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    // Mux select encodings
    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResMem    = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;

    if (CNT_WIDTH == 0) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end

    state_e     state_q;
    state_e     state_d;
    state_e     out_state;
    logic       funct_ok;
    logic [2:0] funct_alu;

    // Decode funct3/funct7b5 into an ALU op; flag encodings this datapath cannot execute
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = AluAdd;
        case (funct3)
            3'b000: begin
                // Only R-type uses funct7b5 to select sub; addi ignores bit 30
                funct_alu = (state_q == StExecR && funct7b5) ? AluSub : AluAdd;
            end
            3'b010: funct_alu = AluSlt;
            3'b100: funct_alu = AluXor;
            3'b110: funct_alu = AluOr;
            default: begin
                funct_ok  = 1'b0;
                funct_alu = AluAdd;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad,
                    OpStore:  state_d = StMemAdr;
                    OpRType:  state_d = StExecR;
                    OpIType:  state_d = StExecI;
                    OpBranch: state_d = StBeq;
                    OpJal:    state_d = StJal;
                    default:  state_d = StIllegal;
                endcase
            end
            // op[5] separates store (0100011) from load (0000011)
            StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
            StMemRead:  state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = StFetch;
            StExecR,
            StExecI:    state_d = funct_ok ? StAluWb : StIllegal;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StJal:      state_d = StAluWb;
            StIllegal:  state_d = StIllegal;
            default:    state_d = StFetch;
        endcase
    end

    // Output decode; while in reset the selects show FETCH values and every enable is held low
    always_comb begin
        out_state   = rst_n ? state_q : StFetch;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = ResAluOut;
        alu_src_a   = SrcAPc;
        alu_src_b   = SrcBRs2;
        alu_control = AluAdd;
        illegal     = 1'b0;
        case (out_state)
            StFetch: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAlu;
            end
            StDecode: begin
                // Precompute branch/jump target oldPC + imm into ALUOut
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
            end
            StMemRead: begin
                adr_src = 1'b1;
            end
            StMemWb: begin
                result_src = ResMem;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            StExecR: begin
                alu_src_a   = SrcARs1;
                alu_src_b   = SrcBRs2;
                alu_control = funct_alu;
            end
            StExecI: begin
                alu_src_a   = SrcARs1;
                alu_src_b   = SrcBImm;
                alu_control = funct_alu;
            end
            StAluWb: begin
                reg_write = 1'b1;
            end
            StBeq: begin
                alu_src_a   = SrcARs1;
                alu_src_b   = SrcBRs2;
                alu_control = AluSub;
                pc_write    = zero;
            end
            StJal: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                pc_write  = 1'b1;
            end
            StIllegal: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
        if (!rst_n) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

`ifdef CTRL_PERF_EN
    logic                 retire;
    logic [CNT_WIDTH-1:0] instret_q;

    // Every state in this set unconditionally returns to FETCH, completing an instruction
    assign retire = (state_q == StMemWb) || (state_q == StMemWrite) ||
                    (state_q == StAluWb) || (state_q == StBeq);

    // Retired-instruction counter, wraps modulo 2^CNT_WIDTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + CNT_WIDTH'(1);
        end
    end

    assign instret = instret_q;
`endif

endmodule
